mission_sequencer: RTL and testbench

MISSION_SEQUENCER -- requirements
Module: mission_sequencer

---
 rtl/mission_sequencer.sv | 120 ++++++++++++
 tb/tb_mission_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mission_sequencer.sv
// mission_sequencer: fault scan / pick / rectify mission FSM driving a path planner
module mission_sequencer #(
  parameter int NUM_UNITS = 3,
  parameter int MAX_WP = 4,
  parameter int NODE_W = 5,
  parameter int CNT_W = 3,
  parameter logic [NUM_UNITS*MAX_WP*NODE_W-1:0] WP_TABLE =
    {5'd0, 5'd24, 5'd27, 5'd29, 5'd0, 5'd2, 5'd5, 5'd7, 5'd12, 5'd15, 5'd17, 5'd19},
  parameter logic [NUM_UNITS*4-1:0] WP_COUNT = {4'd3, 4'd3, 4'd4},
  parameter logic [4*NODE_W-1:0] STORE_NODES = {5'd11, 5'd23, 5'd10, 5'd22},
  parameter logic [NODE_W-1:0] HOME_NODE = '0
) (
  input  logic                 clk_50M,
  input  logic                 rst_n,
  input  logic                 run_en,
  input  logic [NUM_UNITS-1:0] fault_flag,
  input  logic                 pick_block_flag,
  input  logic [1:0]           block_location,
  input  logic [NODE_W-1:0]    realtime_pos,
  input  logic [NODE_W-1:0]    curr_node,
  output logic                 path_req,
  output logic [NODE_W-1:0]    start_point,
  output logic [NODE_W-1:0]    end_point,
  output logic [2:0]           fault_unit,
  output logic [2:0]           fault_id,
  output logic                 all_done,
  output logic [NUM_UNITS-1:0] pending
);
  typedef enum logic [2:0] {IDLE, SCAN, PICK, RECTIFY, HOME, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt [NUM_UNITS];
  logic [2:0] act, wp, sel;
  logic armed, any, leg_done, last, rect_done;
  logic [NODE_W-1:0] wp_node, store_node;
  logic [3:0] wp_cnt;
  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_pend
    assign pending[i] = |cnt[i];
  end
  always_comb begin
    sel = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) if (pending[i]) sel = 3'(i);
  end
  assign any = |pending;
  assign wp_node = WP_TABLE[(int'(act) * MAX_WP + int'(wp)) * NODE_W +: NODE_W];
  assign wp_cnt = WP_COUNT[int'(act) * 4 +: 4];
  assign store_node = STORE_NODES[int'(block_location) * NODE_W +: NODE_W];
  assign last = {1'b0, wp} + 4'd1 == wp_cnt;
  assign leg_done = path_req && armed && curr_node == end_point;
  // combinational so the counter drops on the same edge the FSM returns to IDLE
  assign rect_done = run_en && state == RECTIFY && leg_done && last;
  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_UNITS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++)
        if (fault_flag[i] && !(rect_done && act == 3'(i)) && !(&cnt[i])) cnt[i] <= cnt[i] + 1'b1;
        else if (rect_done && act == 3'(i) && !fault_flag[i] && pending[i]) cnt[i] <= cnt[i] - 1'b1;
    end
  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      act <= '0;
      wp <= '0;
      armed <= 1'b0;
      path_req <= 1'b0;
      start_point <= '0;
      end_point <= '0;
      fault_unit <= '0;
      fault_id <= '0;
      all_done <= 1'b0;
    end else if (run_en) begin
      if (path_req) armed <= 1'b1;
      if (leg_done) begin
        path_req <= 1'b0;
        armed <= 1'b0;
        fault_id <= '0;
      end
      case (state)
        IDLE: begin
          act <= sel;
          wp <= '0;
          fault_unit <= any ? sel + 3'd1 : 3'd0;
          all_done <= !any && realtime_pos == HOME_NODE;
          state <= any ? SCAN : realtime_pos != HOME_NODE ? HOME : DONE;
        end
        SCAN, RECTIFY:
          if (!path_req) begin
            path_req <= 1'b1;
            start_point <= curr_node;
            end_point <= wp_node;
            fault_id <= state == SCAN ? wp : 3'd0;
          end else if (leg_done) begin
            wp <= last ? 3'd0 : wp + 3'd1;
            if (last) state <= state == SCAN ? PICK : IDLE;
            if (last && state == RECTIFY) begin
              act <= '0;
              fault_unit <= '0;
            end
          end
        PICK:
          if (!path_req && pick_block_flag) begin
            path_req <= 1'b1;
            start_point <= curr_node;
            end_point <= store_node;
          end else if (leg_done) state <= RECTIFY;
        HOME:
          if (!path_req) begin
            path_req <= 1'b1;
            start_point <= curr_node;
            end_point <= HOME_NODE;
          end else if (leg_done) state <= IDLE;
        DONE:
          if (any) begin
            all_done <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mission_sequencer.sv
// tb_mission_sequencer: mission-level reference model feeding a leg scoreboard
module tb_mission_sequencer;
  logic clk_50M = 0, rst_n = 0, run_en = 1, pick_block_flag = 0;
  logic [2:0] fault_flag, stim_ff = 0, plan_ff = 0;
  logic [1:0] block_location = 0;
  logic [4:0] realtime_pos = 0, curr_node = 0;
  logic path_req, all_done;
  logic [4:0] start_point, end_point;
  logic [2:0] fault_unit, fault_id, pending;
  assign fault_flag = stim_ff | plan_ff;
  always #10 clk_50M = ~clk_50M;

  mission_sequencer dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .run_en(run_en), .fault_flag(fault_flag),
    .pick_block_flag(pick_block_flag), .block_location(block_location),
    .realtime_pos(realtime_pos), .curr_node(curr_node), .path_req(path_req),
    .start_point(start_point), .end_point(end_point), .fault_unit(fault_unit),
    .fault_id(fault_id), .all_done(all_done), .pending(pending)
  );

  typedef struct {int node; int fid; int funit;} leg_t;
  leg_t sb[$];
  leg_t cur;
  logic [2:0] stim_q[$];
  int checks = 0, failures = 0, legn = 0, coinc = -1;
  int wp_tab[3][4] = '{'{19, 17, 15, 12}, '{7, 5, 2, 0}, '{29, 27, 24, 0}};
  int wp_n[3] = '{4, 3, 3};
  int store[4] = '{22, 10, 23, 11};
  int mcnt[3] = '{0, 0, 0};

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add(logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) mcnt[i] = mcnt[i] < 7 ? mcnt[i] + 1 : 7;
  endtask

  task automatic push_service(int u, int loc);
    for (int w = 0; w < wp_n[u]; w++) sb.push_back(leg_t'{wp_tab[u][w], w, u + 1});
    sb.push_back(leg_t'{store[loc], 0, u + 1});
    for (int w = 0; w < wp_n[u]; w++) sb.push_back(leg_t'{wp_tab[u][w], 0, u + 1});
  endtask

  // service lowest pending unit each round, then one trip home
  task automatic plan_mission(int loc);
    int u;
    forever begin
      u = -1;
      for (int i = 2; i >= 0; i--) if (mcnt[i] > 0) u = i;
      if (u < 0) break;
      push_service(u, loc);
      mcnt[u]--;
    end
    sb.push_back(leg_t'{0, 0, 0});
  endtask

  task automatic pulse(logic [2:0] v);
    @(negedge clk_50M);
    stim_ff = v;
    @(negedge clk_50M);
    stim_ff = 0;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while (!(sb.size() == 0 && all_done && !path_req) && n < 4000) begin
      @(posedge clk_50M);
      #1;
      n++;
    end
    chk({name, "_timeout"}, int'(n < 4000), 1);
    chk({name, "_left"}, sb.size(), 0);
    chk({name, "_pending"}, pending, 0);
    chk({name, "_unit"}, fault_unit, 0);
  endtask

  task automatic phase(string name, int loc);
    block_location = 2'(loc);
    foreach (stim_q[k]) add(stim_q[k]);
    plan_mission(loc);
    foreach (stim_q[k]) pulse(stim_q[k]);
    wait_done(name);
  endtask

  task automatic run_leg();
    logic [4:0] tgt, o;
    int d;
    tgt = end_point;
    legn++;
    if (curr_node == tgt) begin
      realtime_pos = tgt;
      @(posedge clk_50M);
      #2;
      if (!rst_n) return;
      chk("leg_eq_armed", path_req, 1);
      @(posedge clk_50M);
      #2;
      if (!rst_n) return;
      chk("leg_eq_done", path_req, 0);
      return;
    end
    d = $urandom_range(0, 3);
    repeat (d) begin
      @(posedge clk_50M);
      #2;
      if (!rst_n) return;
      do o = 5'($urandom); while (o == tgt);
      curr_node = o;
    end
    @(posedge clk_50M);
    #2;
    if (!rst_n) return;
    if (legn == coinc) plan_ff = 3'b001;
    curr_node = tgt;
    realtime_pos = tgt;
    @(posedge clk_50M);
    #2;
    plan_ff = 0;
    if (!rst_n) return;
    chk("leg_done", path_req, 0);
  endtask

  initial forever begin
    @(posedge clk_50M);
    #2;
    if (rst_n && path_req) run_leg();
  end

  initial forever begin
    @(negedge clk_50M);
    pick_block_flag = $urandom_range(0, 2) != 0;
  end

  initial begin
    logic prev;
    prev = 0;
    forever begin
      @(posedge clk_50M);
      #1;
      if (!rst_n) begin
        prev = 0;
        continue;
      end
      if (path_req && !prev) begin
        chk("leg_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          chk("leg_end", end_point, cur.node);
          chk("leg_start", start_point, curr_node);
          chk("leg_fid", fault_id, cur.fid);
          chk("leg_unit", fault_unit, cur.funit);
        end
      end else if (path_req) chk("leg_hold", end_point, cur.node);
      else chk("idle_fid", fault_id, 0);
      prev = path_req;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [2:0] v;
    repeat (3) @(posedge clk_50M);
    #1;
    chk("rst_path_req", path_req, 0);
    chk("rst_start", start_point, 0);
    chk("rst_end", end_point, 0);
    chk("rst_unit", fault_unit, 0);
    chk("rst_fid", fault_id, 0);
    chk("rst_done", all_done, 0);
    chk("rst_pending", pending, 0);
    @(negedge clk_50M);
    rst_n = 1;
    repeat (2) @(posedge clk_50M);
    #1;
    chk("boot_done", all_done, 1);
    chk("boot_req", path_req, 0);
    block_location = 2;
    add(3'b100);
    plan_mission(2);
    pulse(3'b100);
    chk("u2_pending", pending, 4);
    wait_done("unit2");
    stim_q = '{3'b011};
    phase("dual", 1);
    block_location = 0;
    mcnt[0] = 2;
    coinc = legn + 9;
    plan_mission(0);
    pulse(3'b001);
    wait_done("coincide");
    coinc = -1;
    stim_q = '{};
    repeat (8) stim_q.push_back(3'b010);
    phase("saturate", 3);
    run_en = 0;
    block_location = 1;
    add(3'b100);
    plan_mission(1);
    pulse(3'b100);
    repeat (5) @(posedge clk_50M);
    #1;
    chk("hold_done", all_done, 1);
    chk("hold_req", path_req, 0);
    chk("hold_pending", pending, 4);
    @(negedge clk_50M);
    run_en = 1;
    wait_done("run_en");
    for (int p = 0; p < 6; p++) begin
      stim_q = '{};
      v = 3'($urandom_range(1, 7));
      stim_q.push_back(v);
      repeat ($urandom_range(0, 3)) stim_q.push_back(v & 3'($urandom));
      phase("random", $urandom_range(0, 3));
    end
    block_location = 3;
    add(3'b001);
    plan_mission(3);
    pulse(3'b001);
    n = 0;
    while (!path_req && n < 50) begin
      @(posedge clk_50M);
      #1;
      n++;
    end
    chk("scan_started", path_req, 1);
    @(posedge clk_50M);
    #3;
    rst_n = 0;
    #1;
    chk("async_req", path_req, 0);
    chk("async_unit", fault_unit, 0);
    chk("async_end", end_point, 0);
    chk("async_pending", pending, 0);
    chk("async_done", all_done, 0);
    sb.delete();
    mcnt = '{0, 0, 0};
    repeat (2) @(posedge clk_50M);
    curr_node = 0;
    realtime_pos = 9;
    sb.push_back(leg_t'{0, 0, 0});
    @(negedge clk_50M);
    rst_n = 1;
    wait_done("reset_home");
    chk("final_pos", realtime_pos, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
